// File: rtl/ddr_serialiser.sv
// Parallel-to-serial DDR/SDR pad driver: per-lane shift registers feeding generic ddr_out cells.
// Optional per-word output enable (in_oe/q_oe) is compiled in with `define DDR_SERIALISER_OE_EN.

module ddr_out (
  input  logic clk,
  input  logic rst_n,
  input  logic e,
  input  logic d_rise,
  input  logic d_fall,
  output logic q
);
  logic r_q;
  logic f_q;

  // Both halves are captured on the rising edge; the pad mux shows d_rise while clk is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
      f_q <= 1'b0;
    end else if (e) begin
      r_q <= d_rise;
      f_q <= d_fall;
    end
  end

  assign q = clk ? r_q : f_q;
endmodule

module ddr_serialiser #(
  parameter int W          = 1,
  parameter int RATIO      = 8,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W*RATIO-1:0] in_data,
  input  logic               in_ddr,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               busy,
  output logic               underrun,
  output logic [W-1:0]       q
`ifdef DDR_SERIALISER_OE_EN
  ,
  input  logic [W-1:0]       in_oe,
  output logic [W-1:0]       q_oe
`endif
);
  localparam int CW = $clog2(RATIO) + 1;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           state;
  logic [RATIO-1:0] shreg [W];
  logic [CW-1:0]    count;
  logic             mode;
  logic             chained;
  logic             accept;
  logic             active;

  assign active   = (state == ST_SHIFT);
  assign in_ready = !active || (count == CW'(1));
  assign busy     = active;
  assign accept   = in_valid && in_ready;

  // chained records that the current word followed another with no gap, which is what arms underrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      mode     <= 1'b0;
      chained  <= 1'b0;
      underrun <= 1'b0;
      for (int k = 0; k < W; k++) shreg[k] <= '0;
    end else begin
      underrun <= 1'b0;
      if (accept) begin
        for (int k = 0; k < W; k++) shreg[k] <= in_data[k*RATIO +: RATIO];
        mode    <= in_ddr;
        count   <= in_ddr ? CW'(RATIO / 2) : CW'(RATIO);
        chained <= active;
        state   <= ST_SHIFT;
      end else if (active) begin
        for (int k = 0; k < W; k++) shreg[k] <= mode ? (shreg[k] << 2) : (shreg[k] << 1);
        count <= count - CW'(1);
        if (count == CW'(1)) begin
          state    <= ST_IDLE;
          underrun <= chained;
          chained  <= 1'b0;
        end
      end
    end
  end

`ifdef DDR_SERIALISER_OE_EN
  logic [W-1:0] oe_word;

  // Follows the pair pipeline: enable is set on the edge that samples the word's first pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_word <= '0;
      q_oe    <= '0;
    end else begin
      if (accept) oe_word <= in_oe;
      q_oe <= active ? oe_word : '0;
    end
  end
`endif

  for (genvar k = 0; k < W; k++) begin : g_lane
    logic d_rise;
    logic d_fall;

    assign d_rise = active ? shreg[k][RATIO-1] : IDLE_LEVEL;
    assign d_fall = active ? (mode ? shreg[k][RATIO-2] : shreg[k][RATIO-1]) : IDLE_LEVEL;

    ddr_out u_pad (
      .clk    (clk),
      .rst_n  (rst_n),
      .e      (1'b1),
      .d_rise (d_rise),
      .d_fall (d_fall),
      .q      (q[k])
    );
  end
endmodule

// File: tb/tb_ddr_serialiser.sv
// Scoreboard bench for ddr_serialiser: the driver queues expected pad pairs per accepted word,
// and a monitor pops and compares them on every cycle the serialiser reports busy.

module tb_ddr_serialiser;
  localparam int W    = 2;
  localparam int RATIO = 8;
  localparam int DW   = W * RATIO;
  localparam bit IDLE = 1'b1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ddr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          busy;
  logic          underrun;
  logic [W-1:0]  q;
`ifdef DDR_SERIALISER_OE_EN
  logic [W-1:0]  in_oe = '0;
  logic [W-1:0]  q_oe;
`endif

  ddr_serialiser #(.W(W), .RATIO(RATIO), .IDLE_LEVEL(IDLE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_ddr   (in_ddr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .busy     (busy),
    .underrun (underrun),
    .q        (q)
`ifdef DDR_SERIALISER_OE_EN
    ,
    .in_oe    (in_oe),
    .q_oe     (q_oe)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] oe;
    bit           last;
    bit           chained;
  } pair_t;

  pair_t exp_q[$];
  int    compared   = 0;
  int    mismatched = 0;
  bit    mon_en     = 1'b0;
  bit    prev_busy  = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Handshake expectations follow from how many pad beats are still owed.
  task automatic checkHandshake();
    checkOutput("in_ready", 64'(in_ready), 64'(exp_q.size() <= 1));
    checkOutput("busy", 64'(busy), 64'(exp_q.size() != 0));
  endtask

  task automatic pushWord(input logic [DW-1:0] data, input logic ddr, input logic [W-1:0] oe);
    int beats;
    bit ch;
    beats = ddr ? RATIO / 2 : RATIO;
    ch    = (exp_q.size() != 0);
    for (int b = 0; b < beats; b++) begin
      pair_t p;
      for (int k = 0; k < W; k++) begin
        logic [RATIO-1:0] lw;
        lw = data[k*RATIO +: RATIO];
        if (ddr) begin
          p.rise[k] = lw[RATIO-1-2*b];
          p.fall[k] = lw[RATIO-2-2*b];
        end else begin
          p.rise[k] = lw[RATIO-1-b];
          p.fall[k] = lw[RATIO-1-b];
        end
      end
      p.oe      = oe;
      p.last    = (b == beats - 1);
      p.chained = ch;
      exp_q.push_back(p);
    end
  endtask

  // Garbage is offered while stalled; the real word only appears in the cycle that is accepted.
  task automatic applyStimulus(input logic [DW-1:0] data, input logic ddr, input logic [W-1:0] oe);
    int waited;
    bit done;
    waited = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      in_ddr   = 1'($urandom);
`ifdef DDR_SERIALISER_OE_EN
      in_oe    = W'($urandom);
`endif
      #2;
      checkHandshake();
      if (in_ready) begin
        in_data = data;
        in_ddr  = ddr;
`ifdef DDR_SERIALISER_OE_EN
        in_oe   = oe;
`endif
        pushWord(data, ddr, oe);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 2 * RATIO + 4) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL ready_timeout: in_ready still %0b after %0d cycles, required 1", in_ready, waited);
          in_valid = 1'b0;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = DW'($urandom);
      #2;
      checkHandshake();
    end
  endtask

  // Monitor: the pair shown after an edge belongs to a word iff busy was high in the cycle before it.
  initial begin : monitor
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] oe_s;
    pair_t        p;
    oe_s = '0;
    forever begin
      @(posedge clk);
      #1 hi = q;
`ifdef DDR_SERIALISER_OE_EN
      oe_s = q_oe;
`endif
      @(negedge clk);
      #1 lo = q;
      if (mon_en) begin
        if (prev_busy) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL extra_beat: busy was 1 but no beat expected, required busy 0");
          end else begin
            p = exp_q.pop_front();
            checkOutput("pad_rise", 64'(hi), 64'(p.rise));
            checkOutput("pad_fall", 64'(lo), 64'(p.fall));
            checkOutput("underrun", 64'(underrun), 64'(p.last && p.chained && exp_q.size() == 0));
`ifdef DDR_SERIALISER_OE_EN
            checkOutput("q_oe", 64'(oe_s), 64'(p.oe));
`endif
          end
        end else begin
          checkOutput("idle_rise", 64'(hi), 64'({W{IDLE}}));
          checkOutput("idle_fall", 64'(lo), 64'({W{IDLE}}));
          checkOutput("idle_underrun", 64'(underrun), 64'(0));
`ifdef DDR_SERIALISER_OE_EN
          checkOutput("idle_q_oe", 64'(oe_s), 64'(0));
`endif
        end
      end
      prev_busy = busy;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_q", 64'(q), 64'(0));
    checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_underrun", 64'(underrun), 64'(0));
`ifdef DDR_SERIALISER_OE_EN
    checkOutput("reset_q_oe", 64'(q_oe), 64'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #2 mon_en = 1'b1;

    // Isolated words in each mode, back-to-back pair ending in underrun, then mode switching.
    applyStimulus({8'hA5, 8'h3C}, 1'b1, 2'b11);
    idleCycles(6);
    applyStimulus({8'hA5, 8'h3C}, 1'b0, 2'b01);
    idleCycles(10);
    applyStimulus({8'hFF, 8'hFF}, 1'b1, 2'b10);
    applyStimulus({8'h00, 8'h00}, 1'b1, 2'b11);
    idleCycles(6);
    applyStimulus({8'h12, 8'h34}, 1'b1, 2'b01);
    applyStimulus({8'hF0, 8'hF0}, 1'b0, 2'b10);
    applyStimulus({8'h5A, 8'hC3}, 1'b1, 2'b11);
    idleCycles(12);

    repeat (40) begin
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
      applyStimulus(DW'($urandom), 1'($urandom), W'($urandom));
    end
    idleCycles(2 * RATIO + 4);
    checkOutput("drain_empty", 64'(exp_q.size()), 64'(0));

    // Reset in the middle of a word drops the pads straight to 0.
    mon_en = 1'b0;
    applyStimulus({DW{1'b1}}, 1'b1, {W{1'b1}});
    repeat (3) @(posedge clk);
    #2;
    checkOutput("pre_reset_pad", 64'(q), 64'({W{1'b1}}));
    rst_n = 1'b0;
    #1;
    checkOutput("midword_reset_q", 64'(q), 64'(0));
    checkOutput("midword_reset_busy", 64'(busy), 64'(0));
    checkOutput("midword_reset_in_ready", 64'(in_ready), 64'(1));
    checkOutput("midword_reset_underrun", 64'(underrun), 64'(0));
`ifdef DDR_SERIALISER_OE_EN
    checkOutput("midword_reset_q_oe", 64'(q_oe), 64'(0));
`endif
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_pad", 64'(q), 64'({W{IDLE}}));
    checkOutput("post_reset_busy", 64'(busy), 64'(0));
    checkOutput("post_reset_in_ready", 64'(in_ready), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ddr_serialiser.md
Name: ddr_serialiser

Overview:
- Parallel-to-serial DDR output stage: accepts RATIO-bit words per lane over a valid/ready handshake and shifts them out MSB-first to W pads.
- DDR mode: 2 bits per lane per clk. SDR mode: 1 bit per lane per clk.
- Sits between protocol cores (SPI/QSPI, DVI-style streamers) and the pads.
- Each lane drives one ddr_out cell with e tied high, so the same vendor primitive mapping (iCE40, ECP5, generic sim) is used.

Parameters:
- W, 1, number of output lanes/pads.
- RATIO, 8, bits per lane per word; even, 2..64.
- IDLE_LEVEL, 0, pad level driven on both half-cycles when no word is shifting.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_data  input  W*RATIO  word; lane k occupies bits [k*RATIO +: RATIO]; MSB is sent first
- in_ddr  input  1  mode for this word: 1 = DDR, 0 = SDR; sampled with the word
- in_valid  input  1  word offered
- in_ready  output  1  word accepted on a clk edge when in_valid && in_ready
- busy  output  1  shifter holds untransmitted bits
- underrun  output  1  one-cycle pulse: shifter ran empty while a transfer was in progress and no next word was ready
- q  output  W  pads (via per-lane ddr_out)

Behaviour:
- Reset:
  - shifter empty; beat counter 0; in_ready=1; busy=0; underrun=0.
  - ddr_out cells output 0 while in reset.
  - From the first clk edge after reset release, the pads show IDLE_LEVEL.
- Internal state:
  - per-lane RATIO-bit shift register;
  - beat counter, $clog2(RATIO)+1 bits;
  - stored mode bit;
  - active flag.
- Acceptance at edge N:
  - load the shift registers and mode;
  - counter = RATIO/2 (DDR) or RATIO (SDR);
  - active=1.
- Pair presentation: on each edge while active, the pair {d_rise,d_fall} per lane goes to ddr_out.
  - DDR: {bit RATIO-1, bit RATIO-2}; then shift left by 2.
  - SDR: {bit RATIO-1, bit RATIO-1}; then shift left by 1.
  - Counter decrements each edge.
- Latency: first pair is sampled by ddr_out at edge N+1. The pad shows it in the clk-high phase after N+1 (d_rise) and the following low phase (d_fall).
- Word duration: DDR occupies RATIO/2 cycles, SDR occupies RATIO cycles.
- in_ready = !active || (counter==1).
  - Back-to-back words therefore stream with no idle gap.
  - Mode may change between consecutive words with no gap.
- Last beat with in_valid=0:
  - active clears; the next pair is {IDLE_LEVEL, IDLE_LEVEL}.
  - underrun pulses for one cycle, only if this word was accepted while a previous word was shifting, or was itself followed-on (i.e. only within a stream, never after an isolated word).
  - Simpler decided rule: underrun = 1 for one cycle when counter goes 1->0 with in_valid=0 and the previous word was accepted back-to-back. An isolated single word never flags underrun.
- busy = active.
- in_data/in_ddr changes while in_valid && !in_ready are ignored; no data is latched until acceptance.
- Reset asserted mid-word: the word is discarded immediately; the pads drop to 0 asynchronously via ddr_out reset.
- RATIO=2 in DDR mode: in_ready stays 1 continuously, giving one word per cycle.

Optional Feature:
- Macro: DDR_SERIALISER_OE_EN.
- When defined:
  - extra input in_oe [W] is sampled with the word;
  - extra output q_oe [W] is a registered output enable aligned cycle-exactly with the first pair of that word reaching the pad (edge N+1), held until the word's last pair;
  - q_oe goes to 0 on the edge where idle pairs begin;
  - reset value of q_oe is 0.
- When undefined: no in_oe/q_oe ports; the pads are always driven.

Test Plan:
- W=1, RATIO=8, DDR, single word 0xA5 accepted at edge N -> pad half-cycles from edge N+1 read 1,0,1,0,0,1,0,1. busy high for 4 cycles. Pad returns to IDLE_LEVEL=0. No underrun.
- Same word in SDR mode -> each bit held a full clk; pad 1,0,1,0,0,1,0,1 over 8 cycles. in_ready low for cycles 1..7 after acceptance.
- Back-to-back DDR words 0xFF then 0x00, in_valid held -> 4 cycles of 1 then 4 cycles of 0 with no idle gap. in_ready high on the last beat of the first word.
- Stream of 2 words, third not offered -> underrun pulses exactly one cycle at the end of word 2, then pad shows IDLE_LEVEL.
- W=4, RATIO=4, alternating DDR/SDR words 0x1234/0xF0F0 -> each lane serialises its own nibble MSB-first. The mode switch happens with no gap; lane 3 carries 0x1 then 0xF.
- Assert rst_n low mid-word (after 2 DDR beats) -> q=0 immediately; after release, in_ready=1, busy=0, pad at IDLE_LEVEL. With DDR_SERIALISER_OE_EN, q_oe=0.
